prbs_gen_chk: RTL and testbench
===============================

# prbs_gen_chk

Parametrised PRBS generator and checker for RGMII link bring-up and bit-error-rate testing. The generator emits DATA_WIDTH bits per clock from a run-time selectable polynomial (PRBS7/15/23/31). The checker self-synchronises to a received PRBS stream, tracks lock, and counts bit errors. It sits beside the MAC datapath and drives or monitors the byte stream toward the RGMII transceiver.

## Interface
- DATA_WIDTH, 8: bits produced/checked per clock (1..32).
- LOCK_COUNT, 16: consecutive error-free words needed to declare lock (≥1).
- ERR_LIMIT, 4: consecutive errored words that drop lock (≥1).
- CNT_WIDTH, 32: width of the saturating bit-error counter.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_mode  in  2  polynomial: 0=PRBS7 x^7+x^6+1, 1=PRBS15 x^15+x^14+1, 2=PRBS23 x^23+x^18+1, 3=PRBS31 x^31+x^28+1.
- i_seed_load  in  1  load generator state from i_seed.
- i_seed  in  31  seed; only the low n bits are used for PRBSn.
- i_gen_enable  in  1  advance generator one word.
- o_gen_data  out  DATA_WIDTH  generated word; MSB is the first bit in time.
- o_gen_valid  out  1  o_gen_data updated this cycle.
- i_chk_valid  in  1  i_chk_data is valid.
- i_chk_data  in  DATA_WIDTH  received word; MSB is the first bit.
- i_err_clear  in  1  zero the error counter.
- o_chk_locked  out  1  checker in LOCKED.
- o_chk_err  out  1  last checked word contained ≥1 bit error.
- o_err_count  out  CNT_WIDTH  saturating bit-error total.

## Operation
- Fibonacci XOR LFSR with an n-bit state (n = 7/15/23/31). Per bit, b = s[n-1] ^ s[m-1] (m = second tap), and s <= {s[n-2:0], b}. One word is DATA_WIDTH successive steps.
- Seed load: the state takes i_seed[n-1:0]. An all-zero seed is replaced by all-ones, so the LFSR never locks up. i_seed_load has priority over i_gen_enable.
- Checker state machine:
  - HUNT: the feedback history is taken from the received bits (self-synchronising). Each predicted bit is compared with the received bit. A correct word increments the good-word count. At LOCK_COUNT good words, go to LOCKED. An errored word zeroes the good-word count.
  - LOCKED: the state free-runs on its own predictions. Mismatches are the XOR popcount, which is added to o_err_count. At ERR_LIMIT consecutive errored words, go to HUNT and zero both run counters. An error-free word zeroes the errored-word run count.
- Errors are counted only in LOCKED. The counter saturates at all-ones.
- i_err_clear has priority: the counter becomes 0 and any same-cycle errors are discarded.
- A change on i_mode forces the checker to HUNT and clears its run counters. The generator keeps its state bits but continues with the new taps.
- Cycles with i_chk_valid=0 leave all checker state unchanged.

## Timing
- Reset values: o_gen_data=0, o_gen_valid=0, o_chk_locked=0, o_chk_err=0, o_err_count=0, generator state all-ones, checker in HUNT.
- Generator: o_gen_data and o_gen_valid are registered 1 cycle after i_gen_enable. o_gen_valid is 0 on seed-load cycles.
- Checker: o_chk_err and o_err_count update 1 cycle after i_chk_valid. o_chk_locked rises on the cycle after the LOCK_COUNT-th good word.
- Reset asserted mid-operation returns everything to the reset values immediately. Nothing is pending after reset.

## Configuration
- PRBS_CHECKER_EN defined: checker, lock state machine and error counter are built.
- PRBS_CHECKER_EN undefined: generator only. o_chk_locked, o_chk_err and o_err_count are tied to 0. i_chk_* and i_err_clear are ignored.

## Structure
- prbs_pkg holds:
  - the mode enum;
  - the per-mode length n and tap m constants;
  - the 31-bit state typedef.
- Sub-module prbs_step: combinational DATA_WIDTH-step next-state and output word for a given mode. It has an input that selects feedback from predicted or received bits. It is instantiated once in the generator and once in the checker.

## Test plan
- PRBS7, DATA_WIDTH=8, seed 7'h7F, enable two cycles -> o_gen_data = 8'h02, then 8'h0C.
- Seed 0 in PRBS7 -> same output as seed 7'h7F (8'h02, 8'h0C).
- Loop generator into checker, PRBS31, LOCK_COUNT=16 -> o_chk_locked high after the 16th valid word; o_err_count stays 0 over 10k words.
- While locked, flip one bit in one word -> o_chk_err pulses for 1 cycle, o_err_count=1, lock held. Flip 3 bits in the next word -> o_err_count=4.
- While locked, corrupt ERR_LIMIT=4 consecutive words -> o_chk_locked falls after the 4th; the checker relocks after 16 clean words.
- Preload the counter near saturation by forcing errors with CNT_WIDTH=4 -> holds at 15. Assert i_err_clear together with an errored word -> 0. Assert i_rst_n low mid-stream -> all outputs 0 on the same edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS types, per-mode polynomial constants and helpers.
// Holds the polynomial mode enum, the checker lock states, the 31-bit LFSR
// state type and lookups for register length n, tap m and the n-bit mask.
package prbs_pkg;

    typedef enum logic [1:0] {PRBS7, PRBS15, PRBS23, PRBS31} prbs_mode_e;

    typedef enum logic {CHK_HUNT, CHK_LOCKED} chk_state_e;

    typedef logic [30:0] prbs_state_t;

    localparam int PRBS_N [4] = '{7, 15, 23, 31};
    localparam int PRBS_M [4] = '{6, 14, 18, 28};

    function automatic logic [4:0] prbs_hi(input prbs_mode_e m);
        return 5'(PRBS_N[m] - 1);
    endfunction

    function automatic logic [4:0] prbs_tap(input prbs_mode_e m);
        return 5'(PRBS_M[m] - 1);
    endfunction

    function automatic prbs_state_t prbs_mask(input prbs_mode_e m);
        return prbs_state_t'((32'd1 << PRBS_N[m]) - 32'd1);
    endfunction

endpackage

// File: rtl/prbs_step.sv
// prbs_step: combinational DATA_WIDTH-step Fibonacci LFSR advance.
// Ports: i_mode selects the polynomial, i_state is the current history
// (bit 0 most recent), i_use_rx shifts the received bits i_rx into the
// history instead of the predictions, o_state is the advanced history and
// o_word the predicted bits (MSB first in time).
module prbs_step
    import prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  prbs_mode_e              i_mode,
    input  prbs_state_t             i_state,
    input  logic                    i_use_rx,
    input  logic [DATA_WIDTH-1:0]   i_rx,
    output prbs_state_t             o_state,
    output logic [DATA_WIDTH-1:0]   o_word
);

    logic [4:0]            hi;
    logic [4:0]            tap;
    prbs_state_t           s;
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] r;
    logic                  b;

    assign hi  = prbs_hi(i_mode);
    assign tap = prbs_tap(i_mode);

    // The full 31-bit history shifts regardless of mode, so a mode change
    // keeps every past bit and simply reads different taps.
    always_comb begin
        s = i_state;
        w = '0;
        r = i_rx;
        b = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b = s[hi] ^ s[tap];
            w = (w << 1) | DATA_WIDTH'(b);
            s = {s[29:0], i_use_rx ? r[DATA_WIDTH-1] : b};
            r = r << 1;
        end
        o_state = s;
        o_word  = w;
    end

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: PRBS7/15/23/31 generator plus self-synchronising checker.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_mode polynomial;
// i_seed_load/i_seed/i_gen_enable drive the generator, which presents
// o_gen_data/o_gen_valid; i_chk_valid/i_chk_data feed the checker, which
// reports o_chk_locked, o_chk_err and the saturating o_err_count, cleared by
// i_err_clear. The checker is built only when PRBS_CHECKER_EN is defined;
// otherwise its outputs are tied to 0.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_COUNT = 16,
    parameter int ERR_LIMIT  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_mode,
    input  logic                  i_seed_load,
    input  logic [30:0]           i_seed,
    input  logic                  i_gen_enable,
    output logic [DATA_WIDTH-1:0] o_gen_data,
    output logic                  o_gen_valid,
    input  logic                  i_chk_valid,
    input  logic [DATA_WIDTH-1:0] i_chk_data,
    input  logic                  i_err_clear,
    output logic                  o_chk_locked,
    output logic                  o_chk_err,
    output logic [CNT_WIDTH-1:0]  o_err_count
);

    prbs_mode_e            mode;
    prbs_state_t           gen_state_q, gen_state_d, gen_next, seed_m;
    logic [DATA_WIDTH-1:0] gen_word, gen_data_q, gen_data_d;
    logic                  gen_valid_q, gen_valid_d;

    assign mode = prbs_mode_e'(i_mode);

    prbs_step #(.DATA_WIDTH(DATA_WIDTH)) u_gen_step (
        .i_mode   (mode),
        .i_state  (gen_state_q),
        .i_use_rx (1'b0),
        .i_rx     ('0),
        .o_state  (gen_next),
        .o_word   (gen_word)
    );

    // An all-zero seed would lock the LFSR up, so it becomes all-ones.
    always_comb begin
        seed_m      = i_seed & prbs_mask(mode);
        gen_state_d = i_seed_load ? (seed_m == '0 ? prbs_mask(mode) : seed_m) :
                      i_gen_enable ? gen_next : gen_state_q;
        gen_valid_d = i_gen_enable && !i_seed_load;
        gen_data_d  = gen_valid_d ? gen_word : gen_data_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gen_state_q <= '1;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
        end else begin
            gen_state_q <= gen_state_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
        end
    end

    assign o_gen_data  = gen_data_q;
    assign o_gen_valid = gen_valid_q;

`ifdef PRBS_CHECKER_EN
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam int NW = $clog2(DATA_WIDTH + 1);
    localparam int SW = (CNT_WIDTH > NW ? CNT_WIDTH : NW) + 1;

    chk_state_e            fsm_q, fsm_d;
    prbs_state_t           chk_state_q, chk_state_d, chk_next;
    prbs_mode_e            mode_q;
    logic [GW-1:0]         good_q, good_d;
    logic [EW-1:0]         bad_q, bad_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] pred;
    logic [NW-1:0]         nerr;
    logic [SW-1:0]         sum;

    // While hunting the history is rebuilt from received bits; once locked
    // it free-runs so that line errors do not corrupt later predictions.
    prbs_step #(.DATA_WIDTH(DATA_WIDTH)) u_chk_step (
        .i_mode   (mode),
        .i_state  (chk_state_q),
        .i_use_rx (fsm_q == CHK_HUNT),
        .i_rx     (i_chk_data),
        .o_state  (chk_next),
        .o_word   (pred)
    );

    assign nerr = NW'($countones(pred ^ i_chk_data));
    assign sum  = SW'(cnt_q) + SW'(nerr);

    always_comb begin
        fsm_d       = fsm_q;
        chk_state_d = chk_state_q;
        good_d      = good_q;
        bad_d       = bad_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        if (i_chk_valid) begin
            chk_state_d = chk_next;
            err_d       = fsm_q == CHK_LOCKED && nerr != '0;
            if (fsm_q == CHK_HUNT) begin
                good_d = nerr == '0 ? good_q + 1'b1 : '0;
                if (nerr == '0 && good_q == GW'(LOCK_COUNT - 1)) begin
                    fsm_d  = CHK_LOCKED;
                    good_d = '0;
                end
            end else if (nerr != '0) begin
                cnt_d = sum > SW'({CNT_WIDTH{1'b1}}) ? '1 : sum[CNT_WIDTH-1:0];
                bad_d = bad_q + 1'b1;
                if (bad_q == EW'(ERR_LIMIT - 1)) begin
                    fsm_d  = CHK_HUNT;
                    good_d = '0;
                    bad_d  = '0;
                end
            end else begin
                bad_d = '0;
            end
        end
        if (mode != mode_q) begin
            fsm_d  = CHK_HUNT;
            good_d = '0;
            bad_d  = '0;
        end
        if (i_err_clear)
            cnt_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fsm_q       <= CHK_HUNT;
            chk_state_q <= '1;
            mode_q      <= PRBS7;
            good_q      <= '0;
            bad_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            chk_state_q <= chk_state_d;
            mode_q      <= mode;
            good_q      <= good_d;
            bad_q       <= bad_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign o_chk_locked = fsm_q == CHK_LOCKED;
    assign o_chk_err    = err_q;
    assign o_err_count  = cnt_q;
`else
    logic unused_chk;
    assign unused_chk   = ^{i_chk_valid, i_chk_data, i_err_clear};
    assign o_chk_locked = 1'b0;
    assign o_chk_err    = 1'b0;
    assign o_err_count  = '0;
`endif

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: scoreboard bench with a bit-history reference model.
module tb_prbs_gen_chk;

    localparam int W  = 8;
    localparam int LC = 16;
    localparam int EL = 4;
    localparam int CW = 4;
`ifdef PRBS_CHECKER_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          seed_load = 1'b0;
    logic [30:0]   seed = '0;
    logic          gen_en = 1'b0;
    logic [W-1:0]  gen_data;
    logic          gen_valid;
    logic          chk_valid = 1'b0;
    logic [W-1:0]  chk_data = '0;
    logic          err_clear = 1'b0;
    logic          locked;
    logic          chk_err;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    prbs_gen_chk #(.DATA_WIDTH(W), .LOCK_COUNT(LC), .ERR_LIMIT(EL), .CNT_WIDTH(CW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mode       (mode),
        .i_seed_load  (seed_load),
        .i_seed       (seed),
        .i_gen_enable (gen_en),
        .o_gen_data   (gen_data),
        .o_gen_valid  (gen_valid),
        .i_chk_valid  (chk_valid),
        .i_chk_data   (chk_data),
        .i_err_clear  (err_clear),
        .o_chk_locked (locked),
        .o_chk_err    (chk_err),
        .o_err_count  (err_count)
    );

    typedef struct {
        logic          l;
        logic          e;
        logic [CW-1:0] c;
    } exp_t;

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] gq[$];
    exp_t         cq[$];
    logic [W-1:0] want_q[$];
    bit           gh[$];
    bit           ch[$];
    bit           m_locked, m_err;
    int           m_good, m_bad, m_cnt;
    logic [1:0]   m_prev;
    int           len_n[4] = '{7, 15, 23, 31};
    int           len_m[4] = '{6, 14, 18, 28};
    bit           mon_cv;
    logic [1:0]   cur_mode = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Sequence recurrence: x[k] = x[k-n] ^ x[k-m]; h[$] is the newest bit.
    function automatic bit pr(input bit h[$], input int md);
        return h[h.size() - len_n[md]] ^ h[h.size() - len_m[md]];
    endfunction

    task automatic model_reset();
        gh.delete();
        ch.delete();
        for (int i = 0; i < 31; i++) begin
            gh.push_back(1'b1);
            ch.push_back(1'b1);
        end
        m_locked = 0; m_err = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_prev = 2'd0;
    endtask

    task automatic model_gen(input bit sl, input bit en, input logic [30:0] sd);
        longint       mk;
        logic [30:0]  v;
        logic [W-1:0] w;
        bit           b;
        if (sl) begin
            mk = (longint'(1) << len_n[mode]) - 1;
            v  = sd & mk[30:0];
            if (v == '0) v = mk[30:0];
            gh.delete();
            for (int j = 30; j >= 0; j--) gh.push_back(v[j]);
        end else if (en) begin
            w = '0;
            for (int i = 0; i < W; i++) begin
                b = pr(gh, int'(mode));
                gh.push_back(b);
                void'(gh.pop_front());
                w = {w[W-2:0], b};
            end
            gq.push_back(want_q.size() > 0 ? want_q.pop_front() : w);
        end
    endtask

    task automatic model_chk(input bit v, input logic [W-1:0] d, input bit clr);
        int   ne;
        bit   p;
        exp_t e;
        ne = 0;
        if (v) begin
            for (int i = W - 1; i >= 0; i--) begin
                p = pr(ch, int'(mode));
                if (p != d[i]) ne++;
                ch.push_back(m_locked ? p : d[i]);
                void'(ch.pop_front());
            end
            m_err = m_locked && ne > 0;
            if (!m_locked) begin
                m_good = ne == 0 ? m_good + 1 : 0;
                if (m_good == LC) begin m_locked = 1; m_good = 0; end
            end else if (ne > 0) begin
                m_cnt = m_cnt + ne > 2 ** CW - 1 ? 2 ** CW - 1 : m_cnt + ne;
                m_bad++;
                if (m_bad == EL) begin m_locked = 0; m_good = 0; m_bad = 0; end
            end else begin
                m_bad = 0;
            end
        end
        if (mode != m_prev) begin m_locked = 0; m_good = 0; m_bad = 0; end
        m_prev = mode;
        if (clr) m_cnt = 0;
        if (v) begin
            e.l = CHK_EN && m_locked;
            e.e = CHK_EN && m_err;
            e.c = CHK_EN ? CW'(m_cnt) : '0;
            cq.push_back(e);
        end
    endtask

    // One clock of stimulus; the checker is fed from the generator output.
    task automatic step(input logic [1:0] md, input bit en, input bit sl, input logic [30:0] sd,
                        input logic [W-1:0] fl, input bit clr, input bit drop);
        @(posedge clk);
        #1;
        mode      = md;
        gen_en    = en;
        seed_load = sl;
        seed      = sd;
        err_clear = clr;
        chk_valid = gen_valid && !drop;
        chk_data  = gen_data ^ fl;
        model_gen(sl, en, sd);
        model_chk(chk_valid, chk_data, clr);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gen_data"}, 32'(gen_data), 32'd0);
        chk({tag, "_gen_valid"}, 32'(gen_valid), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_err"}, 32'(chk_err), 32'd0);
        chk({tag, "_count"}, 32'(err_count), 32'd0);
    endtask

    task automatic rand_step();
        logic [W-1:0] fl;
        if ($urandom_range(99, 0) == 0) cur_mode = 2'($urandom_range(3, 0));
        fl = $urandom_range(15, 0) == 0 ? W'(1) << $urandom_range(W - 1, 0) :
             $urandom_range(49, 0) == 0 ? W'($urandom) : '0;
        step(cur_mode, $urandom_range(7, 0) != 0, $urandom_range(199, 0) == 0, 31'($urandom),
             fl, $urandom_range(99, 0) == 0, $urandom_range(9, 0) == 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            mon_cv = chk_valid && rst_n;
            @(negedge clk);
            if (rst_n && gen_valid) begin
                if (gq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL gen_unexpected got=valid want=idle");
                end else chk("gen_data", 32'(gen_data), 32'(gq.pop_front()));
            end
            if (mon_cv) begin
                if (cq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL chk_unexpected got=word want=none");
                end else begin
                    exp_t e;
                    e = cq.pop_front();
                    chk("chk_locked", 32'(locked), 32'(e.l));
                    chk("chk_err", 32'(chk_err), 32'(e.e));
                    chk("chk_count", 32'(err_count), 32'(e.c));
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        want_q = '{8'h02, 8'h0C};
        step(0, 0, 1, 31'h7F, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        want_q = '{8'h02, 8'h0C};
        step(0, 0, 1, 31'h0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        cur_mode = 2'd3;
        step(3, 0, 1, 31'($urandom), 0, 0, 0);
        repeat (40) step(3, 1, 0, 0, 0, 0, 0);
        chk("locked_prbs31", 32'(locked), 32'(CHK_EN));
        repeat (10000) step(3, 1, 0, 0, 0, 0, 0);
        step(3, 1, 0, 0, W'(1) << $urandom_range(W - 1, 0), 0, 0);
        step(3, 1, 0, 0, W'(3'b111) << $urandom_range(W - 3, 0), 0, 0);
        chk("count_one", 32'(err_count), CHK_EN ? 32'd1 : 32'd0);
        step(3, 1, 0, 0, 0, 0, 0);
        chk("count_four", 32'(err_count), CHK_EN ? 32'd4 : 32'd0);
        chk("lock_held", 32'(locked), 32'(CHK_EN));
        step(3, 1, 0, 0, 0, 0, 0);
        chk("err_pulse_end", 32'(chk_err), 32'd0);
        repeat (4) step(3, 1, 0, 0, W'($urandom_range(255, 1)), 0, 0);
        step(3, 1, 0, 0, 0, 0, 0);
        chk("lock_drop", 32'(locked), 32'd0);
        repeat (20) step(3, 1, 0, 0, 0, 0, 0);
        chk("relock", 32'(locked), 32'(CHK_EN));
        repeat (3) step(3, 1, 0, 0, 8'hFF, 0, 0);
        step(3, 1, 0, 0, 0, 0, 0);
        chk("count_sat", 32'(err_count), CHK_EN ? 32'd15 : 32'd0);
        step(3, 1, 0, 0, 8'h10, 1, 0);
        step(3, 1, 0, 0, 0, 0, 0);
        chk("count_clear", 32'(err_count), 32'd0);
        repeat (3000) rand_step();
        cur_mode = 2'd3;
        repeat (30) step(3, 1, 0, 0, 0, 0, 0);
        step(3, 1, 0, 0, 8'h01, 0, 0);
        repeat (2) step(3, 1, 0, 0, 0, 0, 0);
        step(3, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        chk("midreset_gen_q", 32'(gq.size()), 32'd0);
        chk("midreset_chk_q", 32'(cq.size()), 32'd0);
        gq.delete();
        cq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) rand_step();
        repeat (3) step(cur_mode, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("drain_gen_q", 32'(gq.size()), 32'd0);
        chk("drain_chk_q", 32'(cq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
